// File: rtl/microcode_sequencer_stk.sv
// Micro-address sequencer for the SOL-1 control unit: relative jumps and branches,
// fetch/trap entry, IR dispatch, and a LIFO micro-subroutine stack with sticky error flags.
module microcode_sequencer_stk #(
    parameter int                 UADDR_W       = 14,
    parameter int                 OFFSET_W      = 7,
    parameter int                 IR_W          = 8,
    parameter int                 STACK_DEPTH   = 4,
    parameter logic [UADDR_W-1:0] FETCH_ADDR    = 14'h0010,
    parameter logic [UADDR_W-1:0] TRAP_ADDR     = 14'h0020,
    parameter logic [UADDR_W-1:0] DISPATCH_BASE = 14'h0000,
    parameter logic [UADDR_W-1:0] RESET_ADDR    = 14'h0000
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic [2:0]                         typ,
    input  logic [OFFSET_W-1:0]                offset,
    input  logic                               cond,
    input  logic [IR_W-1:0]                    ir,
    input  logic                               int_pending,
    input  logic                               dma_req,
    input  logic                               stall,
    input  logic                               clr_err,
    output logic [UADDR_W-1:0]                 u_address,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic [UADDR_W-1:0]                 stack_top,
    output logic                               stack_ovf,
    output logic                               stack_unf,
    output logic                               in_trap
);

    localparam int                 DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int                 PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL    = DEPTH_W'(STACK_DEPTH);

    localparam logic [2:0] TYP_JUMP     = 3'b000;
    localparam logic [2:0] TYP_BRANCH   = 3'b001;
    localparam logic [2:0] TYP_FETCH    = 3'b010;
    localparam logic [2:0] TYP_DISPATCH = 3'b011;
    localparam logic [2:0] TYP_CALL     = 3'b100;
    localparam logic [2:0] TYP_RETURN   = 3'b101;
    localparam logic [2:0] TYP_CCALL    = 3'b110;
    localparam logic [2:0] TYP_NEXT     = 3'b111;

    logic [UADDR_W-1:0] r_uaddr;
    logic [DEPTH_W-1:0] r_depth;
    logic [UADDR_W-1:0] r_top;
    logic               r_ovf;
    logic               r_unf;
    logic               r_in_trap;
    logic [UADDR_W-1:0] r_stack [STACK_DEPTH];

    logic [UADDR_W-1:0] w_soff;
    logic [UADDR_W-1:0] w_seq;
    logic [UADDR_W-1:0] w_target;
    logic [UADDR_W-1:0] w_next_uaddr;
    logic [DEPTH_W-1:0] w_next_depth;
    logic [UADDR_W-1:0] w_next_top;
    logic [DEPTH_W-1:0] w_below;
    logic [UADDR_W-1:0] w_below_val;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_wr_en;
    logic               w_next_in_trap;
    logic               w_ovf_set;
    logic               w_unf_set;

    assign w_soff      = {{(UADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    assign w_seq       = r_uaddr + {{(UADDR_W-1){1'b0}}, 1'b1};
    assign w_target    = r_uaddr + w_soff;
    assign w_below     = r_depth - DEPTH_W'(2);
    assign w_below_val = (r_depth > DEPTH_W'(1)) ? r_stack[w_below[PTR_W-1:0]] : {UADDR_W{1'b0}};

    // Next-address decode; a stall freezes everything except the flag clear.
    always_comb begin
        w_next_uaddr   = w_seq;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_flush        = 1'b0;
        w_next_in_trap = r_in_trap;
        if (stall) begin
            w_next_uaddr = r_uaddr;
        end else begin
            case (typ)
                TYP_JUMP:     w_next_uaddr = w_target;
                TYP_BRANCH:   w_next_uaddr = cond ? w_target : w_seq;
                TYP_FETCH: begin
                    w_flush        = 1'b1;
                    w_next_in_trap = int_pending | dma_req;
                    w_next_uaddr   = (int_pending | dma_req) ? TRAP_ADDR : FETCH_ADDR;
                end
                TYP_DISPATCH: w_next_uaddr = DISPATCH_BASE + {{(UADDR_W-IR_W){1'b0}}, ir};
                TYP_CALL: begin
                    w_push       = 1'b1;
                    w_next_uaddr = w_target;
                end
                TYP_RETURN: begin
                    w_pop        = 1'b1;
                    w_next_uaddr = (r_depth == DEPTH_W'(0)) ? FETCH_ADDR : r_top;
                end
                TYP_CCALL: begin
                    w_push       = cond;
                    w_next_uaddr = cond ? w_target : w_seq;
                end
                TYP_NEXT:     w_next_uaddr = w_seq;
                default:      w_next_uaddr = w_seq;
            endcase
        end
    end

    assign w_wr_en   = w_push && (r_depth != FULL);
    assign w_ovf_set = w_push && (r_depth == FULL);
    assign w_unf_set = w_pop  && (r_depth == DEPTH_W'(0));

    // Stack occupancy and registered top-of-stack tracking.
    always_comb begin
        w_next_depth = r_depth;
        w_next_top   = r_top;
        if (w_flush) begin
            w_next_depth = DEPTH_W'(0);
            w_next_top   = {UADDR_W{1'b0}};
        end else if (w_wr_en) begin
            w_next_depth = r_depth + DEPTH_W'(1);
            w_next_top   = w_seq;
        end else if (w_pop && (r_depth != DEPTH_W'(0))) begin
            w_next_depth = r_depth - DEPTH_W'(1);
            w_next_top   = w_below_val;
        end else begin
            w_next_depth = r_depth;
            w_next_top   = r_top;
        end
    end

    // State registers; a new error in the same cycle overrides clr_err.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_uaddr   <= RESET_ADDR;
            r_depth   <= DEPTH_W'(0);
            r_top     <= {UADDR_W{1'b0}};
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_in_trap <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= {UADDR_W{1'b0}};
            end
        end else begin
            r_uaddr   <= w_next_uaddr;
            r_depth   <= w_next_depth;
            r_top     <= w_next_top;
            r_in_trap <= w_next_in_trap;
            r_ovf     <= w_ovf_set | (r_ovf & ~clr_err);
            r_unf     <= w_unf_set | (r_unf & ~clr_err);
            if (w_wr_en) begin
                r_stack[r_depth[PTR_W-1:0]] <= w_seq;
            end
        end
    end

    assign u_address   = r_uaddr;
    assign stack_depth = r_depth;
    assign stack_top   = r_top;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;
    assign in_trap     = r_in_trap;

endmodule

// File: tb/tb_microcode_sequencer_stk.sv
// Self-checking bench for microcode_sequencer_stk: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_microcode_sequencer_stk;

    logic        clk = 1'b0;
    logic        arst;
    logic [2:0]  typ;
    logic [6:0]  offset;
    logic        cond;
    logic [7:0]  ir;
    logic        int_pending;
    logic        dma_req;
    logic        stall;
    logic        clr_err;
    logic [13:0] u_address;
    logic [2:0]  stack_depth;
    logic [13:0] stack_top;
    logic        stack_ovf;
    logic        stack_unf;
    logic        in_trap;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_ua;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;
    bit m_trap;

    microcode_sequencer_stk dut (
        .clk(clk), .arst(arst), .typ(typ), .offset(offset), .cond(cond), .ir(ir),
        .int_pending(int_pending), .dma_req(dma_req), .stall(stall), .clr_err(clr_err),
        .u_address(u_address), .stack_depth(stack_depth), .stack_top(stack_top),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf), .in_trap(in_trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("u_address", 32'(u_address), 32'(m_ua));
        chk("stack_depth", 32'(stack_depth), 32'(m_stk.size()));
        chk("stack_top", 32'(stack_top), (m_stk.size() > 0) ? 32'(m_stk[$]) : 32'd0);
        chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
        chk("stack_unf", 32'(stack_unf), 32'(m_unf));
        chk("in_trap", 32'(in_trap), 32'(m_trap));
    endtask

    task automatic model_reset();
        m_ua = 0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_trap = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model by the architectural rules, check after the edge.
    task automatic step(input logic [2:0] t, input logic [6:0] off, input logic c, input logic [7:0] i,
                        input logic ip, input logic dr, input logic st, input logic ce);
        int so, tgt, sq;
        bit ovf_s, unf_s;
        typ = t; offset = off; cond = c; ir = i;
        int_pending = ip; dma_req = dr; stall = st; clr_err = ce;
        ovf_s = 1'b0;
        unf_s = 1'b0;
        so  = off[6] ? int'(off) - 128 : int'(off);
        tgt = (m_ua + so + 16384) % 16384;
        sq  = (m_ua + 1) % 16384;
        if (!st) begin
            case (t)
                3'd0: m_ua = tgt;
                3'd1: m_ua = c ? tgt : sq;
                3'd2: begin
                    m_trap = ip | dr;
                    m_ua = m_trap ? 32 : 16;
                    m_stk.delete();
                end
                3'd3: m_ua = int'(i);
                3'd4, 3'd6: begin
                    if (t == 3'd4 || c) begin
                        if (m_stk.size() == 4) ovf_s = 1'b1;
                        else m_stk.push_back(sq);
                        m_ua = tgt;
                    end else begin
                        m_ua = sq;
                    end
                end
                3'd5: begin
                    if (m_stk.size() == 0) begin
                        m_ua = 16;
                        unf_s = 1'b1;
                    end else begin
                        m_ua = m_stk.pop_back();
                    end
                end
                default: m_ua = sq;
            endcase
        end
        m_ovf = ovf_s | (m_ovf & !ce);
        m_unf = unf_s | (m_unf & !ce);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic goto(input int target);
        int diff;
        int off;
        if (target < 256) step(3'd3, 7'd0, 1'b0, 8'(target), 1'b0, 1'b0, 1'b0, 1'b0);
        else if (target < 8192) step(3'd3, 7'd0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
        else step(3'd3, 7'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            diff = (target - m_ua + 16384) % 16384;
            if (diff == 0) break;
            if (diff <= 63) off = diff;
            else if (diff >= 16384 - 64) off = 128 - (16384 - diff);
            else off = 63;
            step(3'd0, 7'(off), 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("goto_reached", 32'(u_address), 32'(target));
    endtask

    initial begin
        arst = 1'b1;
        typ = 3'd7; offset = 7'd0; cond = 1'b0; ir = 8'd0;
        int_pending = 1'b0; dma_req = 1'b0; stall = 1'b0; clr_err = 1'b0;
        model_reset();
        #12;
        check_model();
        chk("reset_uaddr", 32'(u_address), 32'h0);
        #1 arst = 1'b0;

        // Call / return
        goto(14'h0100);
        step(3'd4, 7'h10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("call_addr", 32'(u_address), 32'h0110);
        chk("call_depth", 32'(stack_depth), 32'd1);
        chk("call_top", 32'(stack_top), 32'h0101);
        step(3'd5, 7'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ret_addr", 32'(u_address), 32'h0101);
        chk("ret_depth", 32'(stack_depth), 32'd0);

        // Signed offset and wrap
        goto(14'h0005);
        step(3'd0, 7'h7F, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("neg_jump", 32'(u_address), 32'h0004);
        goto(14'h3FFF);
        step(3'd7, 7'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("seq_wrap", 32'(u_address), 32'h0000);
        goto(14'h0001);
        step(3'd0, 7'h7E, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("neg_wrap", 32'(u_address), 32'h3FFF);

        // Overflow / underflow
        for (int k = 0; k < 5; k++) step(3'd4, 7'h05, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_depth", 32'(stack_depth), 32'd4);
        chk("ovf_flag", 32'(stack_ovf), 32'd1);
        for (int k = 0; k < 5; k++) step(3'd5, 7'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("unf_addr", 32'(u_address), 32'h0010);
        chk("unf_flag", 32'(stack_unf), 32'd1);
        step(3'd7, 7'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(stack_ovf), 32'd0);
        chk("clr_unf", 32'(stack_unf), 32'd0);

        // Fetch / trap / dispatch
        step(3'd4, 7'h03, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'd4, 7'h03, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_trap_depth", 32'(stack_depth), 32'd2);
        step(3'd2, 7'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("trap_int", 32'(u_address), 32'h0020);
        chk("trap_depth", 32'(stack_depth), 32'd0);
        chk("trap_flag", 32'(in_trap), 32'd1);
        step(3'd2, 7'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("trap_dma", 32'(u_address), 32'h0020);
        step(3'd2, 7'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fetch_addr", 32'(u_address), 32'h0010);
        chk("fetch_flag", 32'(in_trap), 32'd0);
        step(3'd3, 7'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dispatch", 32'(u_address), 32'h00A5);

        // Stall, then conditional call not taken
        for (int k = 0; k < 3; k++) step(3'd4, 7'h08, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_addr", 32'(u_address), 32'h00A5);
        chk("stall_depth", 32'(stack_depth), 32'd0);
        step(3'd4, 7'h08, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("unstall_addr", 32'(u_address), 32'h00AD);
        chk("unstall_depth", 32'(stack_depth), 32'd1);
        goto(14'h0200);
        step(3'd6, 7'h10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ccall_nt_addr", 32'(u_address), 32'h0201);
        chk("ccall_nt_depth", 32'(stack_depth), 32'd1);

        // Reset mid-operation at depth 3
        step(3'd4, 7'h02, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'd4, 7'h02, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_depth", 32'(stack_depth), 32'd3);
        arst = 1'b1;
        #1;
        model_reset();
        check_model();
        chk("async_rst_addr", 32'(u_address), 32'h0);
        #1 arst = 1'b0;
        step(3'd4, 7'h04, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_addr", 32'(u_address), 32'h0004);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            step(3'($urandom_range(0, 7)), 7'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer_stk.md
# microcode_sequencer_stk

Parametrised next-generation microcode address sequencer for the SOL-1 control unit. It produces the registered micro-address that indexes the control-word ROM. It adds the following to the existing jump, conditional branch, fetch/trap and IR dispatch operations:
- signed branch offsets;
- a hardware micro-subroutine call/return stack;
- conditional calls;
- a WAIT-driven stall;
- sticky stack error flags.

Condition evaluation is done upstream; this block consumes the final condition bit.

## Interface
Parameters:
- UADDR_W, 14, micro-address width
- OFFSET_W, 7, branch offset width (two's complement)
- IR_W, 8, opcode width for dispatch
- STACK_DEPTH, 4, return-stack entries (≥1)
- FETCH_ADDR, 14'h0010, fetch routine entry
- TRAP_ADDR, 14'h0020, interrupt/DMA trap entry
- DISPATCH_BASE, 14'h0000, base added to zero-extended IR on dispatch
- RESET_ADDR, 14'h0000, u_address after reset

Ports:
- clk  in  1  rising-edge clock
- arst  in  1  reset; one clock; reset is asynchronous and active-high
- typ  in  3  sequencing type from control word
- offset  in  OFFSET_W  signed branch/call offset
- cond  in  1  final (already inverted/selected) condition
- ir  in  IR_W  instruction register
- int_pending  in  1  pending interrupt
- dma_req  in  1  pending DMA request
- stall  in  1  WAIT; freezes sequencer
- clr_err  in  1  clears sticky error flags
- u_address  out  UADDR_W  current micro-address
- stack_depth  out  $clog2(STACK_DEPTH+1)  occupied entries
- stack_top  out  UADDR_W  top entry (0 when empty)
- stack_ovf  out  1  sticky overflow
- stack_unf  out  1  sticky underflow
- in_trap  out  1  last fetch/trap op took trap path

## Operation
- soff = sign-extended offset; seq = u_address+1. All sums are modulo 2^UADDR_W.
- typ decode (next u_address):
  - 000 jump: u_address+soff
  - 001 branch: cond ? u_address+soff : seq
  - 010 fetch/trap: (int_pending|dma_req) ? TRAP_ADDR : FETCH_ADDR. Also empties the stack (depth←0) and sets in_trap to the trap decision.
  - 011 dispatch: DISPATCH_BASE + zero-extended ir
  - 100 call: push seq; u_address+soff
  - 101 return: pop → u_address
  - 110 conditional call: cond ? (push seq; u_address+soff) : seq
  - 111 next: seq
- Push when depth==STACK_DEPTH:
  - entry dropped; depth unchanged; stack_ovf←1
  - address still jumps to u_address+soff
- Pop when depth==0:
  - u_address←FETCH_ADDR; stack_unf←1
- Stack is LIFO, implemented as a register array plus pointer; no entry shifting visible at the outputs.
- stall=1:
  - u_address, stack, depth and in_trap hold; no push/pop occurs.
  - clr_err still acts.
- clr_err=1 clears both sticky flags. A same-cycle new error wins: the flag is set.

## Timing
- u_address is registered; the next address is combinational from the current u_address and inputs. Latency is 1 clk.
- The ROM is combinational downstream, so the control word is valid in the same cycle as u_address.
- Push/pop, depth and flag updates occur on the same edge as the address update.
- Reset (async assert, any time including mid-call) sets:
  - u_address=RESET_ADDR
  - stack_depth=0
  - stack_top=0
  - stack_ovf=0
  - stack_unf=0
  - in_trap=0
- Release is sampled synchronously by the first rising edge after deassertion.

## Test plan
- Call/return: u_address=0x0100, typ=100, offset=0x10 → 0x0110, depth=1, stack_top=0x0101; then typ=101 → 0x0101, depth=0.
- Signed offset and wrap:
  - 0x0005, typ=000, offset=0x7F → 0x0004
  - 0x3FFF, typ=111 → 0x0000
  - 0x0001, typ=000, offset=0x7E → 0x3FFF
- Overflow/underflow:
  - five consecutive calls → depth=4, stack_ovf=1, fifth return address lost
  - five returns → four correct pops, fifth gives 0x0010 and stack_unf=1
  - clr_err → both flags 0
- Fetch/trap/dispatch:
  - depth=2, typ=010, int_pending=1 → 0x0020, depth=0, in_trap=1
  - repeat with dma_req only → 0x0020
  - neither request → 0x0010, in_trap=0
  - typ=011, ir=0xA5 → 0x00A5
- Stall and conditional call:
  - stall=1 for 3 cycles with typ=100 → u_address and depth unchanged
  - release → call taken once
  - typ=110, cond=0 at 0x0200 → 0x0201, no push
- Reset mid-operation: arst pulsed between clock edges at depth=3 → immediately u_address=0, depth=0, flags 0; operation resumes on the next edge.
